// File: rtl/lc3_dp_pkg.sv
// Shared encodings, memory FSM state type and sign-extension helper for the
// parametrised LC-3 datapath.
package lc3_dp_pkg;

  // Widest datapath the sext helper can serve; callers size-cast to DATA_W.
  localparam int SEXT_W = 64;

  typedef enum logic [1:0] {
    ALUK_ADD  = 2'd0,
    ALUK_AND  = 2'd1,
    ALUK_NOT  = 2'd2,
    ALUK_PASS = 2'd3
  } aluk_t;

  typedef enum logic [1:0] {
    PCMUX_INC   = 2'd0,
    PCMUX_BUS   = 2'd1,
    PCMUX_ADDER = 2'd2,
    PCMUX_HOLD  = 2'd3
  } pcmux_t;

  typedef enum logic [1:0] {
    ADDR2_ZERO  = 2'd0,
    ADDR2_OFF6  = 2'd1,
    ADDR2_OFF9  = 2'd2,
    ADDR2_OFF11 = 2'd3
  } addr2mux_t;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_t;

  // Sign-extend v[msb:0]; the result is truncated to DATA_W by the caller.
  function automatic logic [SEXT_W-1:0] sext(input logic [15:0] v, input int unsigned msb);
    logic [SEXT_W-1:0] t;
    int unsigned       sh;
    sh = SEXT_W - 1 - msb;
    t  = {{(SEXT_W-16){1'b0}}, v} << sh;
    return $unsigned($signed(t) >>> sh);
  endfunction

endpackage

// File: rtl/lc3_datapath_gen_mem_if.sv
// Memory-interface FSM: req/ack handshake with wait states and a timeout.
// Drives the Mem_* control outputs and strobes MDR capture on read acks.
module lc3_mem_if
  import lc3_dp_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic write,
  input  logic ack,
  output logic req,
  output logic we,
  output logic done,
  output logic err,
  output logic capture
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  mem_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             timeout;

  // Last wait cycle: the counter is about to reach MEM_TIMEOUT.
  assign timeout = (cnt == CNT_W'(MEM_TIMEOUT - 1));

  assign req     = (state == MEM_REQ);
  assign done    = (state == MEM_DONE);
  assign capture = req & ack & ~we;

  // State register; reset drops Mem_Req immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MEM_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; ack takes precedence over timeout.
  always_comb begin
    state_nx = state;
    case (state)
      MEM_IDLE: if (start) state_nx = MEM_REQ;
      MEM_REQ:  if (ack || timeout) state_nx = MEM_DONE;
      MEM_DONE: state_nx = MEM_IDLE;
      default:  state_nx = MEM_IDLE;
    endcase
  end

  // Access type latch, wait counter and sticky timeout error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      we  <= 1'b0;
      err <= 1'b0;
    end else begin
      if (state == MEM_IDLE && start) begin
        we  <= write;
        err <= 1'b0;
        cnt <= '0;
      end else if (state == MEM_REQ && !ack) begin
        cnt <= cnt + CNT_W'(1);
        if (timeout) err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/lc3_datapath_gen.sv
// Parametrised LC-3 datapath: PC/IR/MAR/MDR, 8-entry register file, ALU,
// address adder, NZP/BEN and a priority bus, with a handshaked memory port.
module lc3_datapath_gen
  import lc3_dp_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter logic [DATA_W-1:0] PC_RESET    = '0,
  parameter int                MEM_TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              LD_IR,
  input  logic              LD_MDR,
  input  logic              LD_MAR,
  input  logic              LD_PC,
  input  logic              LD_REG,
  input  logic              LD_CC,
  input  logic              LD_BEN,
  input  logic              GatePC,
  input  logic              GateMDR,
  input  logic              GateALU,
  input  logic              GateMARMUX,
  input  logic              ADDR1MUX,
  input  logic              SR1MUX,
  input  logic              SR2MUX,
  input  logic              DRMUX,
  input  logic [1:0]        PCMUX,
  input  logic [1:0]        ADDR2MUX,
  input  logic [1:0]        ALUK,
  input  logic              Mem_Start,
  input  logic              Mem_Write,
  output logic              Mem_Done,
  output logic              Mem_Err,
  output logic              Mem_Req,
  output logic              Mem_We,
  output logic [DATA_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic [DATA_W-1:0] Mem_RData,
  input  logic              Mem_Ack,
  output logic [DATA_W-1:0] IR_Out,
  output logic [DATA_W-1:0] PC_Out,
  output logic [DATA_W-1:0] MAR_Out,
  output logic [DATA_W-1:0] MDR_Out,
  output logic              BEN,
  output logic              Bus_Err
);

  logic [DATA_W-1:0] pc, ir, mar, mdr;
  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] bus, alu, adder, addr1, addr2, sr1_val, sr2_val, pc_next;
  logic [2:0]        sr1_sel, dr_sel;
  logic [2:0]        cc;          // {N, Z, P}
  logic              ben, bus_err, capture;

  assign sr1_sel = SR1MUX ? ir[8:6] : ir[11:9];
  assign dr_sel  = DRMUX ? 3'd7 : ir[11:9];
  assign sr1_val = regs[sr1_sel];
  assign sr2_val = SR2MUX ? DATA_W'(sext(ir[15:0], 4)) : regs[ir[2:0]];
  assign addr1   = ADDR1MUX ? sr1_val : pc;
  assign adder   = addr1 + addr2;

  // Bus source priority PC > MDR > ALU > MARMUX; idle bus reads zero.
  always_comb begin
    bus = '0;
    if (GatePC)          bus = pc;
    else if (GateMDR)    bus = mdr;
    else if (GateALU)    bus = alu;
    else if (GateMARMUX) bus = adder;
  end

  // ALU operation select.
  always_comb begin
    alu = sr1_val;
    case (aluk_t'(ALUK))
      ALUK_ADD:  alu = sr1_val + sr2_val;
      ALUK_AND:  alu = sr1_val & sr2_val;
      ALUK_NOT:  alu = ~sr1_val;
      ALUK_PASS: alu = sr1_val;
      default:   alu = sr1_val;
    endcase
  end

  // Address adder offset select.
  always_comb begin
    addr2 = '0;
    case (addr2mux_t'(ADDR2MUX))
      ADDR2_ZERO:  addr2 = '0;
      ADDR2_OFF6:  addr2 = DATA_W'(sext(ir[15:0], 5));
      ADDR2_OFF9:  addr2 = DATA_W'(sext(ir[15:0], 8));
      ADDR2_OFF11: addr2 = DATA_W'(sext(ir[15:0], 10));
      default:     addr2 = '0;
    endcase
  end

  // Next-PC select.
  always_comb begin
    pc_next = pc;
    case (pcmux_t'(PCMUX))
      PCMUX_INC:   pc_next = pc + DATA_W'(1);
      PCMUX_BUS:   pc_next = bus;
      PCMUX_ADDER: pc_next = adder;
      PCMUX_HOLD:  pc_next = pc;
      default:     pc_next = pc;
    endcase
  end

  // PC, IR and MAR load from the bus side.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc  <= PC_RESET;
      ir  <= '0;
      mar <= '0;
    end else begin
      if (LD_PC)  pc  <= pc_next;
      if (LD_IR)  ir  <= bus;
      if (LD_MAR) mar <= bus;
    end
  end

  // MDR: a memory read capture overrides a same-cycle bus load.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)     mdr <= '0;
    else if (capture) mdr <= Mem_RData;
    else if (LD_MDR)  mdr <= bus;
  end

  // Register file write from the bus.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (LD_REG) begin
      regs[dr_sel] <= bus;
    end
  end

  // Condition codes, branch enable (from current CC) and bus contention flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cc      <= 3'b010;
      ben     <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if (LD_CC)  cc  <= {bus[DATA_W-1], (bus == '0), (~bus[DATA_W-1] & (bus != '0))};
      if (LD_BEN) ben <= |(ir[11:9] & cc);
      bus_err <= ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1);
    end
  end

  lc3_mem_if #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_if (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .start   (Mem_Start),
    .write   (Mem_Write),
    .ack     (Mem_Ack),
    .req     (Mem_Req),
    .we      (Mem_We),
    .done    (Mem_Done),
    .err     (Mem_Err),
    .capture (capture)
  );

  assign Mem_Addr  = mar;
  assign Mem_WData = mdr;
  assign IR_Out    = ir;
  assign PC_Out    = pc;
  assign MAR_Out   = mar;
  assign MDR_Out   = mdr;
  assign BEN       = ben;
  assign Bus_Err   = bus_err;

endmodule

// File: tb/tb_lc3_datapath_gen.sv
// Bench for lc3_datapath_gen: architectural model compared every cycle, plus
// directed vectors with hand-computed literal expectations.
module tb_lc3_datapath_gen;

  localparam int MEM_TO = 4;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        LD_IR, LD_MDR, LD_MAR, LD_PC, LD_REG, LD_CC, LD_BEN;
  logic        GatePC, GateMDR, GateALU, GateMARMUX;
  logic        ADDR1MUX, SR1MUX, SR2MUX, DRMUX;
  logic [1:0]  PCMUX, ADDR2MUX, ALUK;
  logic        Mem_Start, Mem_Write, Mem_Ack;
  logic [15:0] Mem_RData;
  logic        Mem_Done, Mem_Err, Mem_Req, Mem_We, BEN, Bus_Err;
  logic [15:0] Mem_Addr, Mem_WData, IR_Out, PC_Out, MAR_Out, MDR_Out;

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_on   = 1'b0;

  lc3_datapath_gen #(
    .DATA_W(16), .PC_RESET(16'h3000), .MEM_TIMEOUT(MEM_TO)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .LD_IR(LD_IR), .LD_MDR(LD_MDR), .LD_MAR(LD_MAR), .LD_PC(LD_PC),
    .LD_REG(LD_REG), .LD_CC(LD_CC), .LD_BEN(LD_BEN),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .ADDR1MUX(ADDR1MUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .DRMUX(DRMUX),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .Mem_Start(Mem_Start), .Mem_Write(Mem_Write), .Mem_Done(Mem_Done),
    .Mem_Err(Mem_Err), .Mem_Req(Mem_Req), .Mem_We(Mem_We),
    .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData), .Mem_RData(Mem_RData),
    .Mem_Ack(Mem_Ack), .IR_Out(IR_Out), .PC_Out(PC_Out), .MAR_Out(MAR_Out),
    .MDR_Out(MDR_Out), .BEN(BEN), .Bus_Err(Bus_Err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_pc, m_ir, m_mar, m_mdr;
  logic [15:0] m_r [8];
  logic        m_n, m_z, m_p, m_ben, m_berr, m_we, m_err;
  int          m_ph;     // 0 idle, 1 waiting for ack, 2 completion cycle
  int          m_wait;   // cycles spent waiting without ack
  logic [15:0] v_a, v_b, v_alu, v_adr, v_bus;
  logic        v_cap;

  function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
    logic [15:0] hi;
    hi = 16'hFFFF << bits;
    return v[bits-1] ? (v | hi) : (v & ~hi);
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_pc = 16'h3000; m_ir = 0; m_mar = 0; m_mdr = 0;
      for (int i = 0; i < 8; i++) m_r[i] = 0;
      m_n = 0; m_z = 1; m_p = 0; m_ben = 0; m_berr = 0;
      m_we = 0; m_err = 0; m_ph = 0; m_wait = 0;
    end else begin
      v_a = m_r[SR1MUX ? m_ir[8:6] : m_ir[11:9]];
      v_b = SR2MUX ? sx(m_ir, 5) : m_r[m_ir[2:0]];
      case (ALUK)
        2'd0: v_alu = v_a + v_b;
        2'd1: v_alu = v_a & v_b;
        2'd2: v_alu = ~v_a;
        default: v_alu = v_a;
      endcase
      v_adr = (ADDR1MUX ? v_a : m_pc) +
              ((ADDR2MUX == 0) ? 16'h0 : (ADDR2MUX == 1) ? sx(m_ir, 6) :
               (ADDR2MUX == 2) ? sx(m_ir, 9) : sx(m_ir, 11));
      v_bus = GatePC ? m_pc : GateMDR ? m_mdr : GateALU ? v_alu : GateMARMUX ? v_adr : 16'h0;
      v_cap = (m_ph == 1) && Mem_Ack && !m_we;
      m_berr = (int'(GatePC) + int'(GateMDR) + int'(GateALU) + int'(GateMARMUX)) > 1;
      if (LD_BEN) m_ben = (m_ir[11] & m_n) | (m_ir[10] & m_z) | (m_ir[9] & m_p);
      if (LD_CC) begin
        m_n = v_bus[15]; m_z = (v_bus == 0); m_p = !v_bus[15] && (v_bus != 0);
      end
      if (v_cap) m_mdr = Mem_RData;
      else if (LD_MDR) m_mdr = v_bus;
      if (LD_REG) m_r[DRMUX ? 3'd7 : m_ir[11:9]] = v_bus;
      if (LD_PC) begin
        case (PCMUX)
          2'd0: m_pc = m_pc + 1;
          2'd1: m_pc = v_bus;
          2'd2: m_pc = v_adr;
          default: m_pc = m_pc;
        endcase
      end
      if (LD_IR)  m_ir  = v_bus;
      if (LD_MAR) m_mar = v_bus;
      if (m_ph == 0) begin
        if (Mem_Start) begin m_we = Mem_Write; m_err = 0; m_wait = 0; m_ph = 1; end
      end else if (m_ph == 1) begin
        if (Mem_Ack) m_ph = 2;
        else begin
          m_wait++;
          if (m_wait == MEM_TO) begin m_err = 1; m_ph = 2; end
        end
      end else begin
        m_ph = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge Clk) begin
    if (chk_on) begin
      chk("pc", PC_Out, m_pc);
      chk("ir", IR_Out, m_ir);
      chk("mar", MAR_Out, m_mar);
      chk("mdr", MDR_Out, m_mdr);
      chk("mem_addr", Mem_Addr, m_mar);
      chk("mem_wdata", Mem_WData, m_mdr);
      chk("ben", {15'd0, BEN}, {15'd0, m_ben});
      chk("bus_err", {15'd0, Bus_Err}, {15'd0, m_berr});
      chk("mem_req", {15'd0, Mem_Req}, {15'd0, m_ph == 1});
      chk("mem_done", {15'd0, Mem_Done}, {15'd0, m_ph == 2});
      chk("mem_we", {15'd0, Mem_We}, {15'd0, m_we});
      chk("mem_err", {15'd0, Mem_Err}, {15'd0, m_err});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic clr();
    LD_IR = 0; LD_MDR = 0; LD_MAR = 0; LD_PC = 0; LD_REG = 0; LD_CC = 0; LD_BEN = 0;
    GatePC = 0; GateMDR = 0; GateALU = 0; GateMARMUX = 0;
    ADDR1MUX = 0; SR1MUX = 0; SR2MUX = 0; DRMUX = 0;
    PCMUX = 0; ADDR2MUX = 0; ALUK = 0;
    Mem_Start = 0; Mem_Write = 0; Mem_Ack = 0;
  endtask

  // Zero-wait read of value v into MDR, ending back in idle.
  task automatic mem_read(input logic [15:0] v);
    Mem_Start = 1; Mem_Write = 0; tick();
    Mem_Start = 0; Mem_Ack = 1; Mem_RData = v; tick();
    Mem_Ack = 0; tick();
  endtask

  task automatic set_ir(input logic [15:0] v);
    mem_read(v);
    GateMDR = 1; LD_IR = 1; tick(); clr();
  endtask

  int reqc;

  initial begin
    Reset_n = 0; Mem_RData = 0; clr();
    @(posedge Clk); chk_on = 1;
    tick(); tick();
    chk("reset_pc", PC_Out, 16'h3000);
    chk("reset_req", {15'd0, Mem_Req}, 16'h0);
    chk("reset_ben", {15'd0, BEN}, 16'h0);
    #2 Reset_n = 1;
    tick();
    LD_PC = 1; PCMUX = 0; tick(); clr();
    chk("pc_inc", PC_Out, 16'h3001);

    // CC is Z after reset
    set_ir(16'h0400); LD_BEN = 1; tick(); clr();
    chk("ben_reset_z", {15'd0, BEN}, 16'h1);
    set_ir(16'h0A00); LD_BEN = 1; tick(); clr();
    chk("ben_reset_np", {15'd0, BEN}, 16'h0);

    // zero-wait read from 0x0040
    mem_read(16'h0040); GateMDR = 1; LD_MAR = 1; tick(); clr();
    chk("mar_0040", Mem_Addr, 16'h0040);
    Mem_Start = 1; tick(); Mem_Start = 0;
    chk("zw_req_t1", {15'd0, Mem_Req}, 16'h1);
    Mem_Ack = 1; Mem_RData = 16'hBEEF; tick(); Mem_Ack = 0;
    chk("zw_done_t2", {15'd0, Mem_Done}, 16'h1);
    chk("zw_mdr", MDR_Out, 16'hBEEF);
    chk("zw_err", {15'd0, Mem_Err}, 16'h0);
    tick();
    chk("zw_done_pulse", {15'd0, Mem_Done}, 16'h0);

    // write with ack on the third wait cycle
    Mem_Start = 1; Mem_Write = 1; tick(); Mem_Start = 0; Mem_Write = 0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_req", {15'd0, Mem_Req}, 16'h1);
      chk("wr_we", {15'd0, Mem_We}, 16'h1);
      chk("wr_wdata", Mem_WData, 16'hBEEF);
      if (i == 2) begin Mem_Ack = 1; Mem_RData = 16'h1234; end
      tick();
    end
    Mem_Ack = 0;
    chk("wr_done", {15'd0, Mem_Done}, 16'h1);
    chk("wr_mdr_kept", MDR_Out, 16'hBEEF);
    tick();
    chk("wr_done_pulse", {15'd0, Mem_Done}, 16'h0);

    // timeout with no ack
    Mem_Start = 1; tick(); Mem_Start = 0;
    reqc = 0;
    for (int i = 0; i < 20 && !Mem_Done; i++) begin
      if (Mem_Req) reqc++;
      tick();
    end
    chk("to_req_cycles", 16'(reqc), 16'd4);
    chk("to_done", {15'd0, Mem_Done}, 16'h1);
    chk("to_err", {15'd0, Mem_Err}, 16'h1);
    chk("to_mdr_kept", MDR_Out, 16'hBEEF);
    tick();
    Mem_Ack = 1; Mem_RData = 16'hAAAA; tick(); Mem_Ack = 0;
    chk("idle_ack_ignored", MDR_Out, 16'hBEEF);
    chk("err_sticky", {15'd0, Mem_Err}, 16'h1);

    // ack on the last wait cycle beats timeout; start clears error
    Mem_Start = 1; tick(); Mem_Start = 0;
    chk("err_cleared", {15'd0, Mem_Err}, 16'h0);
    repeat (3) tick();
    Mem_Ack = 1; Mem_RData = 16'h7777; tick(); Mem_Ack = 0;
    chk("late_ack_done", {15'd0, Mem_Done}, 16'h1);
    chk("late_ack_err", {15'd0, Mem_Err}, 16'h0);
    chk("late_ack_mdr", MDR_Out, 16'h7777);
    tick();

    // NOT R1,R0 -> R1 = FFFF ; ADD R2,R1,#1 with LD_CC -> 0, Z
    set_ir(16'h923F);
    GateALU = 1; ALUK = 2; SR1MUX = 1; LD_REG = 1; tick(); clr();
    set_ir(16'h1461);
    GateALU = 1; ALUK = 0; SR1MUX = 1; SR2MUX = 1; LD_REG = 1; LD_CC = 1; tick(); clr();
    set_ir(16'h0400); LD_BEN = 1; tick(); clr();
    chk("brz_ben", {15'd0, BEN}, 16'h1);
    set_ir(16'h0800); LD_BEN = 1; tick(); clr();
    chk("brn_ben", {15'd0, BEN}, 16'h0);
    set_ir(16'h0080); GateALU = 1; ALUK = 3; SR1MUX = 1; LD_MAR = 1; tick(); clr();
    chk("r2_zero", MAR_Out, 16'h0000);
    set_ir(16'h0840); GateALU = 1; ALUK = 3; SR1MUX = 1; LD_CC = 1; tick(); clr();
    LD_BEN = 1; tick(); clr();
    chk("brn_after_neg", {15'd0, BEN}, 16'h1);
    // AND R3,R1,#0x0A and a register-register ADD, checked by the model
    set_ir(16'h566A); GateALU = 1; ALUK = 1; SR1MUX = 1; SR2MUX = 1; LD_REG = 1; tick(); clr();
    set_ir(16'h1843); GateALU = 1; SR1MUX = 1; LD_REG = 1; LD_CC = 1; tick(); clr();

    // PC-relative: PC + sext9(0x1FE) = 3001 - 2
    set_ir(16'h0FFE); LD_PC = 1; PCMUX = 2; ADDR2MUX = 2; tick(); clr();
    chk("pc_rel9", PC_Out, 16'h2FFF);
    set_ir(16'h4C00); LD_PC = 1; PCMUX = 2; ADDR2MUX = 3; tick(); clr();
    chk("pc_rel11", PC_Out, 16'h2BFF);
    set_ir(16'h00E5); GateMARMUX = 1; ADDR1MUX = 1; SR1MUX = 1; ADDR2MUX = 1; LD_MAR = 1; tick(); clr();
    LD_PC = 1; PCMUX = 1; GateMDR = 1; tick(); clr();
    LD_PC = 1; PCMUX = 3; tick(); clr();
    LD_PC = 1; PCMUX = 1; GateMARMUX = 1; tick(); clr();

    // bus contention: PC wins, error registered one cycle later
    GatePC = 1; GateALU = 1; LD_MAR = 1; tick();
    chk("contend_mar", MAR_Out, PC_Out);
    chk("contend_err", {15'd0, Bus_Err}, 16'h1);
    GatePC = 0; LD_MAR = 0; tick(); clr();
    chk("contend_clear", {15'd0, Bus_Err}, 16'h0);

    // reset during an access
    Mem_Start = 1; tick(); Mem_Start = 0;
    #2 Reset_n = 0;
    #1;
    chk("rst_mid_req", {15'd0, Mem_Req}, 16'h0);
    chk("rst_mid_mdr", MDR_Out, 16'h0000);
    chk("rst_mid_pc", PC_Out, 16'h3000);
    tick();
    #2 Reset_n = 1;
    tick(); tick();
    chk("post_rst_idle", {15'd0, Mem_Req}, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, expected completion before %0t", $time);
    $fatal(1);
  end

endmodule
